temp_monitor: RTL and testbench

Multi-channel, time-multiplexed temperature classifier and alarm block; the next generation of the single-channel normal/border/warning/emergency decoder. Each channel holds a registered severity state with persistence filtering on escalation, hysteresis on de-escalation, a latched emergency, and optional rate-of-change and sign-flip detection. It sits between the sensor-sample front end (already converted to signed binary) and the display/alarm logic.

---
 rtl/temp_monitor.sv | 112 +++++++++++
 tb/tb_temp_monitor.sv | 133 +++++++++++++
 2 files changed

// File: rtl/temp_monitor.sv
// temp_monitor: multi-channel temperature classifier with persistence, hysteresis and latched emergency.
// Define TEMP_RATE_CHECK_EN to compile in rate-of-change / sign-flip forced emergency.
module temp_monitor #(
  parameter int CH = 4,
  parameter int W = 8,
  parameter int BORDER_T = 40,
  parameter int WARN_T = 47,
  parameter int EMERG_T = 50,
  parameter int HYST = 2,
  parameter int PERSIST = 3,
  parameter int RATE_T = 5,
  localparam int CW = CH > 1 ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_ch,
  input  logic [W-1:0]  in_sample,
  input  logic          clr_valid,
  input  logic [CW-1:0] clr_ch,
  output logic [CH-1:0] normal,
  output logic [CH-1:0] border,
  output logic [CH-1:0] warning,
  output logic [CH-1:0] emergency,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic          alarm
);
  localparam int PW = $clog2(PERSIST + 1);
  localparam logic [2:0] IDLE = 3'd0, NORMAL = 3'd1, BORDER = 3'd2, WARNING = 3'd3, EMERG = 3'd4;
  logic [CH-1:0][2:0] st_q, st_d;
  logic [CH-1:0][PW-1:0] cnt_q, cnt_d;
  logic [CH-1:0][W-1:0] last_q, last_d;
  logic [CH-1:0] have_q, have_d;
  logic in_ok, frc, alarm_d;
  int sx;
  function automatic logic [2:0] lvl(input int x, input int off);
    return x >= EMERG_T - off ? EMERG : x >= WARN_T - off ? WARNING : x >= BORDER_T - off ? BORDER : NORMAL;
  endfunction
`ifdef TEMP_RATE_CHECK_EN
  function automatic logic forced(input logic [W-1:0] s, input logic [W-1:0] l, input logic h);
    logic signed [W:0] d;
    d = $signed({s[W-1], s}) - $signed({l[W-1], l});
    return h && (((d < 0) ? -int'(d) : int'(d)) >= RATE_T || s[W-1] != l[W-1]);
  endfunction
  assign frc = forced(in_sample, last_q[in_ch], have_q[in_ch]);
`else
  assign frc = 1'b0;
`endif
  assign in_ok = in_valid && int'(in_ch) < CH;
  assign sx = int'($signed(in_sample));
  // A clear that hits an EMERGENCY channel wins over a same-cycle sample, which is then discarded.
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    last_d = last_q;
    have_d = have_q;
    alarm_d = 1'b0;
    for (int c = 0; c < CH; c++) begin
      if (clr_valid && int'(clr_ch) == c && st_q[c] == EMERG) begin
        st_d[c] = NORMAL;
        cnt_d[c] = '0;
      end else if (in_ok && int'(in_ch) == c) begin
        last_d[c] = in_sample;
        have_d[c] = 1'b1;
        if (st_q[c] == IDLE) st_d[c] = lvl(sx, 0);
        else if (st_q[c] != EMERG) begin
          if (frc) begin
            st_d[c] = EMERG;
            cnt_d[c] = '0;
          end else if (lvl(sx, 0) > st_q[c]) begin
            if (int'(cnt_q[c]) + 1 >= PERSIST) begin
              st_d[c] = lvl(sx, 0);
              cnt_d[c] = '0;
            end else cnt_d[c] = cnt_q[c] + 1'b1;
          end else begin
            cnt_d[c] = '0;
            if (lvl(sx, HYST) < st_q[c]) st_d[c] = lvl(sx, HYST);
          end
        end
      end
      alarm_d = alarm_d | (st_d[c] == EMERG && st_q[c] != EMERG);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
      have_q <= '0;
      out_valid <= 1'b0;
      out_ch <= '0;
      alarm <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      have_q <= have_d;
      out_valid <= in_ok;
      if (in_ok) out_ch <= in_ch;
      alarm <= alarm_d;
    end
  end
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      normal[c] = st_q[c] == NORMAL;
      border[c] = st_q[c] == BORDER;
      warning[c] = st_q[c] == WARNING;
      emergency[c] = st_q[c] == EMERG;
    end
  end
endmodule

// File: tb/tb_temp_monitor.sv
// tb_temp_monitor: scoreboard bench for temp_monitor with hand-computed directed vectors.
module tb_temp_monitor;
`ifdef TEMP_RATE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam logic [3:0] N = 4'b1000, B = 4'b0100, WN = 4'b0010, E = 4'b0001;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, clr_valid = 1'b0, b_valid = 1'b0;
  logic [1:0] in_ch = '0, clr_ch = '0, b_ch = '0, out_ch, b_out_ch;
  logic [7:0] in_sample = '0;
  logic [3:0] normal, border, warning, emergency;
  logic [2:0] b_normal, b_border, b_warning, b_emergency;
  logic out_valid, alarm, b_out_valid, b_alarm;
  typedef struct {logic [1:0] ch; logic [3:0] f; logic a;} exp_t;
  exp_t q[$];
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  temp_monitor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_sample(in_sample),
    .clr_valid(clr_valid), .clr_ch(clr_ch), .normal(normal), .border(border), .warning(warning),
    .emergency(emergency), .out_valid(out_valid), .out_ch(out_ch), .alarm(alarm)
  );
  temp_monitor #(.CH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ch(b_ch), .in_sample(in_sample),
    .clr_valid(1'b0), .clr_ch(2'd0), .normal(b_normal), .border(b_border), .warning(b_warning),
    .emergency(b_emergency), .out_valid(b_out_valid), .out_ch(b_out_ch), .alarm(b_alarm)
  );
  function automatic logic [3:0] fl(input int c);
    return {normal[c], border[c], warning[c], emergency[c]};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected out_valid: ch %0d with empty scoreboard", out_ch);
      end else begin
        x = q.pop_front();
        chk("out_ch", 32'(out_ch), 32'(x.ch));
        chk("flags", 32'(fl(x.ch)), 32'(x.f));
        chk("alarm", 32'(alarm), 32'(x.a));
      end
    end else chk("alarm idle", 32'(alarm), 0);
  end
  task automatic smp(input int c, input int s, input logic [3:0] f, input logic a);
    in_valid = 1'b1;
    in_ch = c[1:0];
    in_sample = s[7:0];
    q.push_back('{c[1:0], f, a});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic clr(input int c);
    clr_valid = 1'b1;
    clr_ch = c[1:0];
    @(posedge clk);
    #1 clr_valid = 1'b0;
  endtask
  task automatic reset_check();
    chk("rst normal", 32'(normal), 0);
    chk("rst border", 32'(border), 0);
    chk("rst warning", 32'(warning), 0);
    chk("rst emergency", 32'(emergency), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_ch", 32'(out_ch), 0);
    chk("rst alarm", 32'(alarm), 0);
  endtask
  initial begin
    #2 reset_check();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    smp(0, 20, N, 1'b0);
    smp(1, 30, N, 1'b0);
    smp(1, 42, RC ? E : N, RC);
    smp(1, 42, RC ? E : N, 1'b0);
    smp(1, 42, RC ? E : B, 1'b0);
    smp(2, 45, B, 1'b0);
    smp(2, 39, RC ? E : B, RC);
    smp(2, 37, RC ? E : N, 1'b0);
    smp(3, 10, N, 1'b0);
    smp(3, 51, RC ? E : N, RC);
    smp(3, 51, RC ? E : N, 1'b0);
    smp(3, 51, E, !RC);
    smp(3, 10, E, 1'b0);
    clr(3);
    chk("clear ch3", 32'(fl(3)), 32'(N));
    #1 rst_n = 1'b0;
    #1 reset_check();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    smp(0, 20, N, 1'b0);
    smp(0, 26, RC ? E : N, RC);
    smp(1, 2, N, 1'b0);
    smp(1, -1, RC ? E : N, RC);
    smp(2, 48, WN, 1'b0);
    smp(2, 46, WN, 1'b0);
    smp(2, 44, B, 1'b0);
    smp(3, 60, E, 1'b1);
    clr_valid = 1'b1;
    clr_ch = 2'd3;
    smp(3, 60, N, 1'b0);
    clr_valid = 1'b0;
    smp(3, 61, N, 1'b0);
    smp(3, 61, N, 1'b0);
    smp(3, 61, E, 1'b1);
    b_valid = 1'b1;
    b_ch = 2'd3;
    in_sample = 8'd20;
    @(posedge clk);
    #1 chk("oor out_valid", 32'(b_out_valid), 0);
    chk("oor normal", 32'(b_normal), 0);
    b_ch = 2'd2;
    @(posedge clk);
    #1 b_valid = 1'b0;
    chk("inrange out_valid", 32'(b_out_valid), 1);
    chk("inrange normal", 32'(b_normal), 32'b100);
    chk("inrange out_ch", 32'(b_out_ch), 2);
    repeat (2) @(posedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
